// File: rtl/agex_muldiv_seq.sv
// Radix-2 multi-cycle multiply/divide sequencer next to the AGEX ALU.
// Optional macro MULDIV_EARLY_OUT_EN: MUL exits CALC once the remaining multiplier is zero.
module agex_muldiv_seq #(
   parameter int DBITS   = 32,
   parameter int CNTBITS = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [DBITS-1:0] opa_i,
   input  logic [DBITS-1:0] opb_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [DBITS-1:0] result_o
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
   localparam logic [1:0] S_FIXUP = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [2:0] OP_MUL  = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd1;
   localparam logic [2:0] OP_DIVU = 3'd2;
   localparam logic [2:0] OP_REM  = 3'd3;
   localparam logic [2:0] OP_REMU = 3'd4;

   logic [1:0]         state_q, state_d;
   logic [CNTBITS-1:0] cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [DBITS-1:0]   a_q, a_d;
   logic [DBITS-1:0]   b_q, b_d;
   logic [DBITS:0]     rem_q, rem_d;
   logic               neg_q, neg_d;
   logic               sgn_a_q, sgn_a_d;
   logic [DBITS-1:0]   result_q, result_d;

   logic               accept, signed_op, special, calc_exit;
   logic [DBITS-1:0]   abs_a, abs_b, spec_res, prod;
   logic [DBITS:0]     rem_sh, diff;

   always_comb begin
      accept    = (state_q == S_IDLE) && start_i && !flush_i;
      signed_op = (op_i == OP_DIV) || (op_i == OP_REM);
      abs_a     = (signed_op && opa_i[DBITS-1]) ? -opa_i : opa_i;
      abs_b     = (signed_op && opb_i[DBITS-1]) ? -opb_i : opb_i;

      // Cases resolved at accept without iterating; the overflow case yields the dividend itself.
      special  = 1'b0;
      spec_res = '0;
      if (op_i > OP_REMU) begin
         special = 1'b1;
      end else if (op_i != OP_MUL && opb_i == '0) begin
         special  = 1'b1;
         spec_res = (op_i == OP_DIV || op_i == OP_DIVU) ? '1 : opa_i;
      end else if (signed_op && opa_i == {1'b1, {(DBITS-1){1'b0}}} && opb_i == '1) begin
         special  = 1'b1;
         spec_res = (op_i == OP_DIV) ? opa_i : '0;
      end

      prod   = rem_q[DBITS-1:0] + (b_q[0] ? a_q : '0);
      rem_sh = {rem_q[DBITS-1:0], a_q[DBITS-1]};
      diff   = rem_sh - {1'b0, b_q};

`ifdef MULDIV_EARLY_OUT_EN
      calc_exit = (cnt_q == '0) || (op_q == OP_MUL && b_q[DBITS-1:1] == '0);
`else
      calc_exit = (cnt_q == '0);
`endif
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      neg_d    = neg_q;
      sgn_a_d  = sgn_a_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = op_i;
               cnt_d   = CNTBITS'(DBITS - 1);
               neg_d   = opa_i[DBITS-1] ^ opb_i[DBITS-1];
               sgn_a_d = opa_i[DBITS-1];
               a_d     = (op_i == OP_MUL) ? opa_i : abs_a;
               b_d     = (op_i == OP_MUL) ? opb_i : abs_b;
               rem_d   = '0;
               if (special) begin
                  result_d = spec_res;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (op_q == OP_MUL) begin
               rem_d = {1'b0, prod};
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
            end else if (!diff[DBITS]) begin
               rem_d = diff;
               a_d   = {a_q[DBITS-2:0], 1'b1};
            end else begin
               rem_d = rem_sh;
               a_d   = {a_q[DBITS-2:0], 1'b0};
            end
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (calc_exit) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            case (op_q)
               OP_MUL:  result_d = rem_q[DBITS-1:0];
               OP_DIV:  result_d = neg_q ? -a_q : a_q;
               OP_DIVU: result_d = a_q;
               OP_REM:  result_d = sgn_a_q ? -rem_q[DBITS-1:0] : rem_q[DBITS-1:0];
               OP_REMU: result_d = rem_q[DBITS-1:0];
               default: result_d = '0;
            endcase
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      // A flush discards the op entirely, including a result about to be written.
      if (flush_i) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         neg_q    <= 1'b0;
         sgn_a_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         neg_q    <= neg_d;
         sgn_a_q  <= sgn_a_d;
         result_q <= result_d;
      end
   end

   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = (state_q == S_DONE) && !flush_i;
   assign result_o = result_q;
endmodule

// File: tb/tb_agex_muldiv_seq.sv
// Directed bench for agex_muldiv_seq: driver tasks push expected results and done cycles,
// a negedge monitor pops and compares whenever done_o is seen.
module tb_agex_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [2:0]   op_i;
  logic [W-1:0] opa_i;
  logic [W-1:0] opb_i;
  logic         flush_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           t0;

  agex_muldiv_seq #(.DBITS(32), .CNTBITS(6)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .opa_i(opa_i),
    .opb_i(opb_i), .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mul_lat(input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    int m;
    m = 1;
    for (int i = 0; i < W; i++) if (b[i]) m = i + 1;
    return m + 2;
`else
    return 34;
`endif
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h expected=no_done (cycle %0d)", result_o, cyc);
      end else begin
        logic [W-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", result_o, e);
        check("done_cycle", W'(cyc), W'(ec));
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic wait_idle();
    for (int i = 0; i < 200 && busy_o; i++) @(negedge clk);
    if (busy_o) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat, input bit push);
    wait_idle();
    start_i = 1'b1;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    t0      = cyc;
    if (push) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(t0 + lat);
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", W'(busy_o), 0);
    check("reset_done", W'(done_o), 0);
    check("reset_result", result_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // MUL 7 x -3, busy through cycle 34
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, mul_lat(32'hFFFFFFFD), 1'b1);
    for (int c = 1; c <= 34; c++) begin
      check("mul_busy", W'(busy_o), 1);
      @(negedge clk);
    end
    check("mul_idle_35", W'(busy_o), 0);

    // signed / unsigned division
    issue(3'd1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 1'b1);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1'b1);
    issue(3'd1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34, 1'b1);
    issue(3'd3, 32'd100, 32'hFFFFFFF9, 32'd2, 34, 1'b1);
    issue(3'd2, 32'd100, 32'd7, 32'd14, 34, 1'b1);

    // special cases, done in cycle 1
    issue(3'd2, 32'd100, 32'd0, 32'hFFFFFFFF, 1, 1'b1);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b1);
    issue(3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b1);
    issue(3'd4, 32'd5, 32'd0, 32'd5, 1, 1'b1);
    issue(3'd7, 32'd5, 32'd3, 32'd0, 1, 1'b1);
    issue(3'd4, 32'd100, 32'd7, 32'd2, 34, 1'b1);
    wait_drain();

    // flush in cycle 10 together with a start request
    issue(3'd1, 32'd1000, 32'd3, 32'd0, 34, 1'b0);
    repeat (8) @(negedge clk);
    flush_i = 1'b1; start_i = 1'b1; op_i = 3'd2; opa_i = 32'd9; opb_i = 32'd0;
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    check("flush_busy", W'(busy_o), 0);
    check("flush_result", result_o, 32'd2);
    issue(3'd0, 32'd3, 32'd4, 32'd12, mul_lat(32'd4), 1'b1);
    wait_drain();

    // start held through DONE: second accept only once idle again
    wait_idle();
    start_i = 1'b1; op_i = 3'd2; opa_i = 32'd100; opb_i = 32'd0;
    t0 = cyc;
    exp_q.push_back(32'hFFFFFFFF); exp_cyc_q.push_back(t0 + 1);
    @(negedge clk);
    check("hold_busy_done", W'(busy_o), 1);
    exp_q.push_back(32'hFFFFFFFF); exp_cyc_q.push_back(t0 + 3);
    @(negedge clk);
    check("hold_idle", W'(busy_o), 0);
    @(negedge clk);
    start_i = 1'b0;
    check("hold_reaccept", W'(busy_o), 1);
    wait_drain();

    // start held together with flush: never accepted
    wait_idle();
    start_i = 1'b1; flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_start_busy", W'(busy_o), 0);
    end
    start_i = 1'b0; flush_i = 1'b0;

    // reset mid-operation in cycle 20
    issue(3'd0, 32'd3, 32'd5, 32'd0, 34, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", W'(busy_o), 0);
    check("rst_mid_done", W'(done_o), 0);
    check("rst_mid_result", result_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // multiplier length dependence
    issue(3'd0, 32'd5, 32'd3, 32'd15, mul_lat(32'd3), 1'b1);
    issue(3'd0, 32'd9, 32'd0, 32'd0, mul_lat(32'd0), 1'b1);
    issue(3'd0, 32'h12345678, 32'd16, 32'h23456780, mul_lat(32'd16), 1'b1);
    wait_drain();
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
